// File: rtl/lfsr_byte_collector.sv
// ---------------------------------------------------------------------------
// lfsr_byte_collector
//
// Assembles a serial bit stream (LSB first) from an upstream LFSR stage into
// bytes. Each completed byte is compared against a reference byte and pushed
// into a small first-word-fall-through FIFO.
//
// Parameters
//   DEPTH      number of byte entries in the FIFO (power of two, 2..16)
//
// Ports
//   clk        single clock, all state updates on its rising edge
//   rst        asynchronous, active-high reset
//   ser_in     serial data bit
//   ser_valid  ser_in carries a valid bit this cycle
//   expected   reference byte, sampled at the edge that samples bit 7
//   rd_en      pop request for the FIFO head
//   rd_data    FIFO head byte (8'h00 while empty)
//   empty      FIFO holds no bytes (registered)
//   full       FIFO holds DEPTH bytes (registered)
//   match      one-cycle pulse: completed byte equals the reference
//   mismatch   one-cycle pulse: completed byte differs from the reference
//   abort      one-cycle pulse: a partial byte was discarded
//   overflow   sticky: a completed byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module lfsr_byte_collector #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  input  logic       ser_valid,
  input  logic [7:0] expected,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       match,
  output logic       mismatch,
  output logic       abort,
  output logic       overflow
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  // -------------------------------------------------------------------------
  // Bit-collection FSM
  // -------------------------------------------------------------------------
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       byte_done;
  logic       abort_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      shreg_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    byte_done = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ser_valid) begin
          shreg_d[0] = ser_in;
          cnt_d      = 3'd1;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (ser_valid) begin
          shreg_d[cnt_q] = ser_in;
          // The 3-bit counter wraps 7 -> 0, so a completed byte leaves us in
          // COLLECT at count 0, ready to take bit 0 of the next byte with no
          // dead cycle.
          cnt_d          = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            byte_done = 1'b1;
          end
        end else begin
          // Count 0 here means a byte just completed and the stream paused:
          // nothing partial to throw away, so no abort.
          if (cnt_q != 3'd0) begin
            abort_d = 1'b1;
          end
          cnt_d   = 3'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Completed-byte stage: holds the byte and its reference for one cycle so
  // the FIFO write and the compare pulses land together one edge later.
  // -------------------------------------------------------------------------
  logic       wr_pend_q;
  logic [7:0] wr_byte_q;
  logic [7:0] exp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend_q <= 1'b0;
      wr_byte_q <= 8'h00;
      exp_q     <= 8'h00;
    end else begin
      wr_pend_q <= byte_done;
      if (byte_done) begin
        // Bit 7 is still on ser_in at this edge; bits 0..6 are registered.
        wr_byte_q <= {ser_in, shreg_q[6:0]};
        exp_q     <= expected;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, full_q;
  logic          do_push, do_pop;

  // A pop in the write cycle frees a slot, so a full FIFO still accepts the
  // write. A pop is never honoured while empty, so write+pop on an empty
  // FIFO only writes.
  assign do_pop  = rd_en && !empty_q;
  assign do_push = wr_pend_q && (!full_q || do_pop);
  assign count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_byte_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == DEPTH_CNT);
    end
  end

  // -------------------------------------------------------------------------
  // Status pulses and sticky overflow
  // -------------------------------------------------------------------------
  logic match_q, mismatch_q, abort_q, overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      abort_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // The compare result is reported even when the byte itself is dropped.
      match_q    <= wr_pend_q && (wr_byte_q == exp_q);
      mismatch_q <= wr_pend_q && (wr_byte_q != exp_q);
      abort_q    <= abort_d;
      if (wr_pend_q && !do_push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Head is shown combinationally from the registered pointer; the stale
  // array contents are masked to zero while the FIFO is empty.
  assign rd_data  = empty_q ? 8'h00 : mem_q[rd_ptr_q];
  assign empty    = empty_q;
  assign full     = full_q;
  assign match    = match_q;
  assign mismatch = mismatch_q;
  assign abort    = abort_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_lfsr_byte_collector.sv
// ---------------------------------------------------------------------------
// tb_lfsr_byte_collector
//
// Directed bench for lfsr_byte_collector (DEPTH = 4). Inputs are driven on
// the falling edge, outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_lfsr_byte_collector;

  logic       clk;
  logic       rst;
  logic       ser_in;
  logic       ser_valid;
  logic [7:0] expected;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       match;
  logic       mismatch;
  logic       abort;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  lfsr_byte_collector #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ser_in   (ser_in),
    .ser_valid(ser_valid),
    .expected (expected),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .match    (match),
    .mismatch (mismatch),
    .abort    (abort),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Eight consecutive valid cycles, LSB first; expected held throughout.
  task automatic send_byte(input logic [7:0] b, input logic [7:0] e);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < 8; i++) begin
      tick();
      ser_valid = 1'b1;
      ser_in    = v[i];
      expected  = e;
    end
    $display("byte sent data=%h expected=%h", b, e);
  endtask

  // Called at a falling edge: check head, pop it, land on the next falling edge.
  task automatic pop_check(input string tag, input logic [7:0] e);
    chk(tag, rd_data, e);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    $display("pop expected=%h", e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"},    {7'd0, empty},    8'd1);
    chk({tag, "_full"},     {7'd0, full},     8'd0);
    chk({tag, "_match"},    {7'd0, match},    8'd0);
    chk({tag, "_mismatch"}, {7'd0, mismatch}, 8'd0);
    chk({tag, "_abort"},    {7'd0, abort},    8'd0);
    chk({tag, "_overflow"}, {7'd0, overflow}, 8'd0);
    chk({tag, "_rd_data"},  rd_data,          8'h00);
  endtask

  initial begin
    rst       = 1'b1;
    ser_in    = 1'b0;
    ser_valid = 1'b0;
    expected  = 8'h00;
    rd_en     = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;

    // ---- pop while empty is ignored ----
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pop_empty_empty", {7'd0, empty}, 8'd1);

    // ---- 0x93 with matching reference; write+pop while empty ----
    send_byte(8'h93, 8'h93);
    tick();
    ser_valid = 1'b0;
    rd_en     = 1'b1;
    chk("m93_match_early", {7'd0, match}, 8'd0);
    tick();
    rd_en = 1'b0;
    chk("m93_empty",    {7'd0, empty},    8'd0);
    chk("m93_rd_data",  rd_data,          8'h93);
    chk("m93_match",    {7'd0, match},    8'd1);
    chk("m93_mismatch", {7'd0, mismatch}, 8'd0);
    tick();
    chk("m93_match_once", {7'd0, match}, 8'd0);
    chk("m93_no_abort",   {7'd0, abort}, 8'd0);
    pop_check("m93_pop", 8'h93);
    chk("m93_empty_after", {7'd0, empty}, 8'd1);

    // ---- 0x93 against 0x39 ----
    send_byte(8'h93, 8'h39);
    tick();
    ser_valid = 1'b0;
    tick();
    chk("mm_mismatch", {7'd0, mismatch}, 8'd1);
    chk("mm_match",    {7'd0, match},    8'd0);
    chk("mm_rd_data",  rd_data,          8'h93);
    tick();
    chk("mm_mismatch_once", {7'd0, mismatch}, 8'd0);
    pop_check("mm_pop", 8'h93);

    // ---- abort after four bits, then a fresh byte ----
    tick(); ser_valid = 1'b1; ser_in = 1'b1;
    tick(); ser_in = 1'b0;
    tick(); ser_in = 1'b1;
    tick(); ser_in = 1'b1;
    tick(); ser_valid = 1'b0;
    tick();
    chk("ab_abort", {7'd0, abort}, 8'd1);
    chk("ab_empty", {7'd0, empty}, 8'd1);
    tick();
    chk("ab_abort_once", {7'd0, abort}, 8'd0);
    send_byte(8'hA5, 8'hA5);
    tick();
    ser_valid = 1'b0;
    tick();
    chk("ab_fresh_rd_data", rd_data,       8'hA5);
    chk("ab_fresh_match",   {7'd0, match}, 8'd1);
    pop_check("ab_fresh_pop", 8'hA5);

    // ---- five back-to-back bytes into a 4-deep FIFO ----
    for (int k = 1; k <= 5; k++) begin
      send_byte(8'(k), 8'(k));
    end
    tick();
    ser_valid = 1'b0;
    tick();
    chk("ov_full",     {7'd0, full},     8'd1);
    chk("ov_overflow", {7'd0, overflow}, 8'd1);
    chk("ov_match",    {7'd0, match},    8'd1);
    pop_check("ov_pop1", 8'h01);
    pop_check("ov_pop2", 8'h02);
    pop_check("ov_pop3", 8'h03);
    pop_check("ov_pop4", 8'h04);
    chk("ov_empty",       {7'd0, empty},    8'd1);
    chk("ov_sticky",      {7'd0, overflow}, 8'd1);

    // ---- clear overflow, then write+pop while full ----
    rst = 1'b1;
    tick();
    chk_reset_vals("rst2");
    rst = 1'b0;
    send_byte(8'h11, 8'h11);
    send_byte(8'h22, 8'h22);
    send_byte(8'h33, 8'h33);
    send_byte(8'h44, 8'h44);
    send_byte(8'hAA, 8'hAA);
    tick();
    ser_valid = 1'b0;
    rd_en     = 1'b1;
    chk("wp_full_before", {7'd0, full}, 8'd1);
    tick();
    rd_en = 1'b0;
    chk("wp_full",     {7'd0, full},     8'd1);
    chk("wp_overflow", {7'd0, overflow}, 8'd0);
    chk("wp_match",    {7'd0, match},    8'd1);
    pop_check("wp_pop22", 8'h22);
    pop_check("wp_pop33", 8'h33);
    pop_check("wp_pop44", 8'h44);
    pop_check("wp_popAA", 8'hAA);
    chk("wp_empty", {7'd0, empty}, 8'd1);

    // ---- reset mid-byte with a stored byte present ----
    send_byte(8'h77, 8'h77);
    tick(); ser_valid = 1'b1; ser_in = 1'b1;
    tick(); ser_in = 1'b0;
    tick(); ser_in = 1'b1;
    tick(); ser_in = 1'b0;
    tick(); ser_in = 1'b1;
    tick();
    chk("mid_stored", {7'd0, empty}, 8'd0);
    rst       = 1'b1;
    ser_valid = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    tick();
    chk_reset_vals("rst3");
    rst = 1'b0;
    ser_valid = 1'b1;
    ser_in    = 1'b0;
    expected  = 8'h5C;
    // bit 0 of 8'h5C is driven above; the remaining seven follow.
    for (int i = 1; i < 8; i++) begin
      logic [7:0] v;
      v = 8'h5C;
      tick();
      ser_in = v[i];
    end
    tick();
    ser_valid = 1'b0;
    tick();
    chk("post_rst_rd_data", rd_data,       8'h5C);
    chk("post_rst_match",   {7'd0, match}, 8'd1);
    chk("post_rst_abort",   {7'd0, abort}, 8'd0);
    pop_check("post_rst_pop", 8'h5C);
    chk("post_rst_empty", {7'd0, empty}, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
